// File: rtl/bombsquad_pkg.sv
// Shared types and constants for the sequence puzzle controller.
// State enum, symbol codes, LFSR seed and display command.
package bombsquad_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_SHOW,
    S_ENTRY,
    S_CHECK,
    S_PASS,
    S_FAIL
  } state_t;

  localparam logic [3:0]  SYM0      = 4'b1110;
  localparam logic [3:0]  SYM1      = 4'b1101;
  localparam logic [3:0]  SYM2      = 4'b1011;
  localparam logic [3:0]  SYM3      = 4'b0111;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [7:0]  DISP_SHOW = 8'h10;

  // Fibonacci taps 16,14,13,11 shifting toward the MSB.
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [3:0] sym_of(input logic [1:0] c);
    logic [3:0] s;
    s = SYM0;
    unique case (c)
      2'd0: s = SYM0;
      2'd1: s = SYM1;
      2'd2: s = SYM2;
      2'd3: s = SYM3;
    endcase
    return s;
  endfunction

  function automatic logic [15:0] gen_seq(input logic [15:0] l);
    logic [15:0] s;
    s = '0;
    for (int k = 0; k < 4; k++) begin
      s[4*k +: 4] = sym_of(l[2*k +: 2]);
    end
    return s;
  endfunction

endpackage

// File: rtl/sequence_puzzle_ctrl_btn_edge.sv
// btn_edge: two-flop synchroniser plus registered rising-edge pulse.
// The pulse appears three clocks after the raw input edge.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      s3    <= s2;
      pulse <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/sequence_puzzle_ctrl.sv
// Memory-sequence puzzle: show a random 4-symbol target, collect entries, score.
// Optional ENTRY_TIMEOUT_EN adds an idle-entry timeout that costs a strike.
module sequence_puzzle_ctrl
  import bombsquad_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int SHOW_SEC    = 2,
  parameter int MAX_STRIKES = 3
`ifdef ENTRY_TIMEOUT_EN
  ,
  parameter int ENTRY_TIMEOUT_SEC = 10
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        btn_move,
  input  logic        btn_next,
  input  logic [3:0]  sel_code,
  output logic [15:0] sequence_out,
  output logic [7:0]  display_cmd,
  output logic        one_sec,
  output logic        move_pulse,
  output logic        next_pulse,
  output logic        solved,
  output logic        failed,
  output logic        strike,
  output logic [1:0]  strikes,
  output logic        busy
);

  localparam int DW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int SW = $clog2(SHOW_SEC + 1);

  logic [DW-1:0] div;
  logic [15:0]   lfsr;
  logic          mv_raw;
  logic          nx_raw;
  state_t        state;
  logic [SW-1:0] show_cnt;
  logic [1:0]    idx;
  logic [15:0]   entry_q;
  logic [1:0]    strikes_inc;
  logic          hit_max;
  logic          do_strike;

  btn_edge u_move (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_move),
    .pulse (mv_raw)
  );

  btn_edge u_next (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_next),
    .pulse (nx_raw)
  );

  // next wins a same-cycle tie with move
  assign next_pulse = nx_raw;
  assign move_pulse = mv_raw & ~nx_raw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div     <= '0;
      one_sec <= 1'b0;
      lfsr    <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_step(lfsr);
      if (div == DW'(CLK_HZ - 1)) begin
        div     <= '0;
        one_sec <= 1'b1;
      end else begin
        div     <= div + 1'b1;
        one_sec <= 1'b0;
      end
    end
  end

`ifdef ENTRY_TIMEOUT_EN
  localparam int TW = $clog2(ENTRY_TIMEOUT_SEC + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;

  assign tmo_hit = (state == S_ENTRY) && !next_pulse && one_sec
                && (tmo_cnt == TW'(ENTRY_TIMEOUT_SEC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (state != S_ENTRY || next_pulse) begin
      tmo_cnt <= '0;
    end else if (one_sec) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  logic tmo_hit;
  assign tmo_hit = 1'b0;
`endif

  assign strikes_inc = strikes + 2'd1;
  assign hit_max     = (strikes_inc == 2'(MAX_STRIKES));

  always_comb begin
    do_strike = tmo_hit;
    if (state == S_CHECK && entry_q != sequence_out) begin
      do_strike = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      sequence_out <= '0;
      display_cmd  <= '0;
      solved       <= 1'b0;
      failed       <= 1'b0;
      strike       <= 1'b0;
      strikes      <= '0;
      busy         <= 1'b0;
      show_cnt     <= '0;
      idx          <= '0;
      entry_q      <= '0;
    end else begin
      display_cmd <= '0;
      strike      <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_GEN;
            busy  <= 1'b1;
          end
        end
        S_GEN: begin
          sequence_out <= gen_seq(lfsr);
          strikes      <= '0;
          idx          <= '0;
          show_cnt     <= '0;
          display_cmd  <= DISP_SHOW;
          state        <= S_SHOW;
        end
        S_SHOW: begin
          if (one_sec) begin
            if (show_cnt == SW'(SHOW_SEC - 1)) begin
              state <= S_ENTRY;
              idx   <= '0;
            end else begin
              show_cnt <= show_cnt + 1'b1;
            end
          end
        end
        S_ENTRY: begin
          if (next_pulse) begin
            entry_q[4*idx +: 4] <= sel_code;
            idx                 <= idx + 2'd1;
            if (idx == 2'd3) begin
              state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (entry_q == sequence_out) begin
            state  <= S_PASS;
            solved <= 1'b1;
            busy   <= 1'b0;
          end
        end
        S_PASS: state <= S_PASS;
        S_FAIL: state <= S_FAIL;
        default: state <= S_IDLE;
      endcase

      if (do_strike) begin
        strike  <= 1'b1;
        strikes <= (strikes == 2'(MAX_STRIKES)) ? strikes : strikes_inc;
        if (hit_max) begin
          state  <= S_FAIL;
          failed <= 1'b1;
          busy   <= 1'b0;
        end else begin
          state       <= S_SHOW;
          display_cmd <= DISP_SHOW;
          show_cnt    <= '0;
          idx         <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sequence_puzzle_ctrl.sv
// Scoreboard bench for sequence_puzzle_ctrl (CLK_HZ=10, SHOW_SEC=2).
// Build with +define+ENTRY_TIMEOUT_EN to exercise the entry timeout.
module tb_sequence_puzzle_ctrl;
  import bombsquad_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        btn_move;
  logic        btn_next;
  logic [3:0]  sel_code;
  logic [15:0] sequence_out;
  logic [7:0]  display_cmd;
  logic        one_sec;
  logic        move_pulse;
  logic        next_pulse;
  logic        solved;
  logic        failed;
  logic        strike;
  logic [1:0]  strikes;
  logic        busy;

  int checks = 0;
  int fails  = 0;

  sequence_puzzle_ctrl #(
    .CLK_HZ      (10),
    .SHOW_SEC    (2),
    .MAX_STRIKES (3)
`ifdef ENTRY_TIMEOUT_EN
    ,
    .ENTRY_TIMEOUT_SEC (3)
`endif
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .btn_move     (btn_move),
    .btn_next     (btn_next),
    .sel_code     (sel_code),
    .sequence_out (sequence_out),
    .display_cmd  (display_cmd),
    .one_sec      (one_sec),
    .move_pulse   (move_pulse),
    .next_pulse   (next_pulse),
    .solved       (solved),
    .failed       (failed),
    .strike       (strike),
    .strikes      (strikes),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Reference LFSR, stepped from the same reset release as the design.
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge reset) begin
    if (!reset) m_lfsr <= 16'hACE1;
    else m_lfsr <= {m_lfsr[14:0],
                    m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  function automatic logic [15:0] exp_seq(input logic [15:0] l);
    logic [15:0] s;
    s = '0;
    for (int k = 0; k < 4; k++) s[4*k +: 4] = ~(4'b0001 << l[2*k +: 2]);
    return s;
  endfunction

  typedef enum {EV_SHOW, EV_STRIKE, EV_SOLVED, EV_FAILED} ev_e;
  typedef struct {
    ev_e         ev;
    logic [15:0] seq;
    logic [1:0]  stk;
  } exp_t;
  exp_t sb[$];

  task automatic push(input ev_e e, input logic [15:0] s, input logic [1:0] k);
    exp_t x;
    x.ev = e;
    x.seq = s;
    x.stk = k;
    sb.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic sb_pop(input ev_e e);
    exp_t x;
    checks++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL sb_%s: event with nothing expected", e.name());
    end else begin
      x = sb.pop_front();
      if (x.ev != e || sequence_out !== x.seq || strikes !== x.stk) begin
        fails++;
        $display("FAIL sb: got %s seq=%h strikes=%0d expected %s seq=%h strikes=%0d",
                 e.name(), sequence_out, strikes, x.ev.name(), x.seq, x.stk);
      end
    end
  endtask

  logic sol_d = 1'b0;
  logic fail_d = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      sol_d = 1'b0;
      fail_d = 1'b0;
    end else begin
      if (strike) sb_pop(EV_STRIKE);
      if (display_cmd == 8'h10) sb_pop(EV_SHOW);
      if (solved && !sol_d) sb_pop(EV_SOLVED);
      if (failed && !fail_d) sb_pop(EV_FAILED);
      sol_d = solved;
      fail_d = failed;
    end
  end

  task automatic wait_sec(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!one_sec && n < 100);
    if (n >= 100) begin
      fails++;
      $display("FAIL one_sec_timeout: got none expected pulse");
    end
  endtask

  task automatic press_next(input logic [3:0] code);
    @(negedge clk);
    sel_code = code;
    btn_next = 1'b1;
    repeat (4) @(negedge clk);
    btn_next = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic play(input logic [15:0] s, input int bad, input int n);
    logic [3:0] c;
    for (int i = 0; i < n; i++) begin
      c = s[4*i +: 4];
      if (i == bad) c = (c == 4'b1110) ? 4'b1101 : 4'b1110;
      press_next(c);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic start_puzzle(output logic [15:0] s, input logic [1:0] k);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("gen_busy", busy, 1);
    s = exp_seq(m_lfsr);
    push(EV_SHOW, s, k);
    repeat (25) @(negedge clk);
    chk("reach_entry", dut.state, S_ENTRY);
  endtask

  initial begin
    logic [15:0] seq;
    int n;
    int acc;
    reset = 1'b0;
    start = 1'b0;
    btn_move = 1'b0;
    btn_next = 1'b0;
    sel_code = 4'b1110;
    repeat (3) @(negedge clk);
    chk("rst_seq", sequence_out, 0);
    chk("rst_disp", display_cmd, 0);
    chk("rst_flags", {solved, failed, busy, strike, one_sec}, 0);
    chk("rst_strikes", strikes, 0);
    chk("rst_pulses", {move_pulse, next_pulse}, 0);
    reset = 1'b1;

    wait_sec(n);
    chk("one_sec_first", n, 10);
    wait_sec(n);
    chk("one_sec_period", n, 10);

    btn_move = 1'b1;
    btn_next = 1'b1;
    repeat (2) @(negedge clk);
    chk("btn_early", next_pulse, 0);
    @(negedge clk);
    chk("both_next", next_pulse, 1);
    chk("both_move", move_pulse, 0);
    @(negedge clk);
    chk("both_width", {next_pulse, move_pulse}, 0);
    btn_move = 1'b0;
    btn_next = 1'b0;
    repeat (4) @(negedge clk);
    btn_move = 1'b1;
    repeat (3) @(negedge clk);
    chk("move_alone", {move_pulse, next_pulse}, 2'b10);
    btn_move = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 btn_next = 1'b1;
    #3 btn_next = 1'b0;
    acc = 0;
    repeat (6) begin
      @(negedge clk);
      acc += int'(next_pulse);
    end
    chk("glitch", acc, 0);

    // Start phased so SHOW begins just after a one_sec pulse.
    wait_sec(n);
    repeat (9) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("gen_state", dut.state, S_GEN);
    chk("gen_busy", busy, 1);
    seq = exp_seq(m_lfsr);
    push(EV_SHOW, seq, 0);
    @(negedge clk);
    chk("show_cmd", display_cmd, 8'h10);
    chk("show_seq", sequence_out, seq);
    @(negedge clk);
    chk("show_cmd_off", display_cmd, 0);
    repeat (18) @(negedge clk);
    chk("show_at_19", dut.state, S_SHOW);
    @(negedge clk);
    chk("entry_at_20", dut.state, S_ENTRY);
    push(EV_SOLVED, seq, 0);
    play(seq, -1, 4);
    chk("pass_flags", {solved, failed, busy}, 3'b100);
    chk("pass_strikes", strikes, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pass_hold", {solved, busy}, 2'b10);
    chk("pass_seq", sequence_out, seq);

    do_reset();
    start_puzzle(seq, 0);
    for (int r = 1; r <= 3; r++) begin
      push(EV_STRIKE, seq, 2'(r));
      if (r < 3) push(EV_SHOW, seq, 2'(r));
      else push(EV_FAILED, seq, 2'd3);
      play(seq, 2, 4);
      if (r < 3) begin
        repeat (25) @(negedge clk);
        chk("reentry", dut.state, S_ENTRY);
      end
    end
    chk("fail_flags", {solved, failed, busy}, 3'b010);
    chk("fail_strikes", strikes, 3);

    do_reset();
    start_puzzle(seq, 0);
    play(seq, -1, 2);
    #2 reset = 1'b0;
    #1;
    chk("async_seq", sequence_out, 0);
    chk("async_flags", {solved, failed, busy, strike}, 0);
    chk("async_strikes", strikes, 0);
    chk("async_state", dut.state, S_IDLE);
    @(negedge clk);
    reset = 1'b1;
    start_puzzle(seq, 0);
    push(EV_SOLVED, seq, 0);
    play(seq, -1, 4);
    chk("fresh_solved", {solved, strikes}, 3'b100);

    do_reset();
    start_puzzle(seq, 0);
`ifdef ENTRY_TIMEOUT_EN
    push(EV_STRIKE, seq, 1);
    push(EV_SHOW, seq, 1);
    n = 0;
    while (!strike && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_strike", strike, 1);
    chk("timeout_show", dut.state, S_SHOW);
`else
    repeat (40) @(negedge clk);
    chk("no_timeout", dut.state, S_ENTRY);
    chk("no_timeout_stk", strikes, 0);
`endif
    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1);
  end

endmodule
